// File: rtl/vdp_pkg.sv
// Shared VDP constants: active raster size, default Game Gear viewport,
// and the colour RAM geometry used by the final pixel stage.
package vdp_pkg;

    localparam int ACTIVE_W    = 256;
    localparam int ACTIVE_H    = 192;

    localparam int VIEW_X0_DEF = 48;
    localparam int VIEW_Y0_DEF = 24;
    localparam int VIEW_W_DEF  = 160;
    localparam int VIEW_H_DEF  = 144;

    localparam int CRAM_W      = 12;
    localparam int CRAM_DEPTH  = 32;
    localparam int IDX_W       = 5;

    typedef logic [IDX_W-1:0]  cram_idx_t;
    typedef logic [CRAM_W-1:0] cram_word_t;

endpackage

// File: rtl/vdp_cram.sv
// 32x12 colour RAM: one synchronous write port, one synchronous read port.
// A same-edge read of the entry being written returns the old contents.
module vdp_cram
    import vdp_pkg::*;
(
    input  logic       clk_i,
    input  logic       we_i,
    input  cram_idx_t  waddr_i,
    input  cram_word_t wdata_i,
    input  cram_idx_t  raddr_i,
    output cram_word_t rdata_o
);

    cram_word_t mem [CRAM_DEPTH];
    cram_word_t rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/vdp_pixel_mixer.sv
// Final VDP pixel stage: resolves the palette index from background, sprite
// and control rules, looks it up in CRAM and emits registered RGB + de.
module vdp_pixel_mixer
    import vdp_pkg::*;
#(
    parameter int VIEW_X0 = VIEW_X0_DEF,
    parameter int VIEW_Y0 = VIEW_Y0_DEF,
    parameter int VIEW_W  = VIEW_W_DEF,
    parameter int VIEW_H  = VIEW_H_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic [5:0] bg_color,
    input  logic       bg_priority,
    input  logic [3:0] spr_color,
    input  logic [3:0] backdrop,
    input  logic       mask_col0,
    input  logic       display_en,
    input  logic       cram_we,
    input  logic [5:0] cram_a,
    input  logic [7:0] cram_d,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       de
);

    localparam logic [9:0] ACT_X  = 10'(ACTIVE_W);
    localparam logic [9:0] ACT_Y  = 10'(ACTIVE_H);
    localparam logic [9:0] VX_LO  = 10'(VIEW_X0);
    localparam logic [9:0] VX_HI  = 10'(VIEW_X0 + VIEW_W);
    localparam logic [9:0] VY_LO  = 10'(VIEW_Y0);
    localparam logic [9:0] VY_HI  = 10'(VIEW_Y0 + VIEW_H);

    logic       active;
    logic       bg_wins;
    cram_idx_t  idx_d, idx_q;
    logic       vp_d, vp_q;
    logic       de_d, de_q;
    logic [7:0] latch_d, latch_q;
    logic       wr_en_d, wr_en_q;
    cram_idx_t  wr_addr_d, wr_addr_q;
    cram_word_t wr_data_d, wr_data_q;
    cram_word_t cram_rdata;
    cram_word_t rgb;
    logic       unused_bg0;

    // Bit 0 of the background colour is always zero upstream.
    assign unused_bg0 = bg_color[0];

    assign active  = (pixel_x < ACT_X) && (pixel_y < ACT_Y);
    // An opaque (non-zero) priority tile hides the sprite.
    assign bg_wins = bg_priority && (bg_color[4:1] != 4'd0);

    always_comb begin
        idx_d = {1'b1, backdrop};
        if (active && display_en && !(mask_col0 && (pixel_x < 10'd8))) begin
            if ((spr_color != 4'd0) && !bg_wins) begin
                idx_d = {1'b1, spr_color};
            end else begin
                idx_d = bg_color[5:1];
            end
        end
    end

    assign vp_d = (pixel_x >= VX_LO) && (pixel_x < VX_HI)
               && (pixel_y >= VY_LO) && (pixel_y < VY_HI);
    assign de_d = vp_q;

    // CPU writes are staged one cycle so the RAM write lands on the same
    // edge as the read for the pixel resolved alongside the odd strobe.
    always_comb begin
        latch_d = latch_q;
        if (cram_we && !cram_a[0]) begin
            latch_d = cram_d;
        end
    end

    assign wr_en_d   = cram_we && cram_a[0];
    assign wr_addr_d = cram_a[5:1];
    assign wr_data_d = {cram_d[3:0], latch_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q     <= '0;
            vp_q      <= 1'b0;
            de_q      <= 1'b0;
            latch_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            idx_q     <= idx_d;
            vp_q      <= vp_d;
            de_q      <= de_d;
            latch_q   <= latch_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    vdp_cram u_cram (
        .clk_i   (clk),
        .we_i    (wr_en_q),
        .waddr_i (wr_addr_q),
        .wdata_i (wr_data_q),
        .raddr_i (idx_q),
        .rdata_o (cram_rdata)
    );

    // The RAM read register has no reset; gating with the reset-cleared
    // de_q blanks RGB outside the viewport and immediately on reset.
    assign rgb   = de_q ? cram_rdata : '0;
    assign red   = rgb[3:0];
    assign green = rgb[7:4];
    assign blue  = rgb[11:8];
    assign de    = de_q;

endmodule

// File: tb/tb_vdp_pixel_mixer.sv
// Scoreboard bench for vdp_pixel_mixer: one default-viewport instance and
// one full-screen-viewport instance, both driven by the same pixel stream.
module tb_vdp_pixel_mixer;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] pixel_x, pixel_y;
  logic [5:0] bg_color;
  logic       bg_priority;
  logic [3:0] spr_color, backdrop;
  logic       mask_col0, display_en, cram_we;
  logic [5:0] cram_a;
  logic [7:0] cram_d;
  logic [3:0] red_a, green_a, blue_a, red_b, green_b, blue_b;
  logic       de_a, de_b;

  always #5 clk = ~clk;

  vdp_pixel_mixer u_dut_a (
    .clk(clk), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .bg_color(bg_color), .bg_priority(bg_priority), .spr_color(spr_color),
    .backdrop(backdrop), .mask_col0(mask_col0), .display_en(display_en),
    .cram_we(cram_we), .cram_a(cram_a), .cram_d(cram_d),
    .red(red_a), .green(green_a), .blue(blue_a), .de(de_a)
  );

  vdp_pixel_mixer #(.VIEW_X0(0), .VIEW_Y0(0), .VIEW_W(256), .VIEW_H(192)) u_dut_b (
    .clk(clk), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .bg_color(bg_color), .bg_priority(bg_priority), .spr_color(spr_color),
    .backdrop(backdrop), .mask_col0(mask_col0), .display_en(display_en),
    .cram_we(cram_we), .cram_a(cram_a), .cram_d(cram_d),
    .red(red_b), .green(green_b), .blue(blue_b), .de(de_b)
  );

  logic [11:0] m_cram [32];
  logic [7:0]  m_latch;
  logic [12:0] exp_q[$];
  logic [12:0] exp_b_q[$];
  string       tag_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  logic [3:0] s_bd;
  logic       s_mask, s_den;
  logic       w_en;
  logic [5:0] w_a;
  logic [7:0] w_d;

  task automatic check_eq(input string tag, input logic [12:0] got, input logic [12:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] model_index(input logic [9:0] x, input logic [9:0] y,
                                             input logic [5:0] bg, input logic pri,
                                             input logic [3:0] spr);
    if (x >= 10'd256 || y >= 10'd192) return {1'b1, s_bd};
    if (!s_den) return {1'b1, s_bd};
    if (s_mask && x < 10'd8) return {1'b1, s_bd};
    if (spr != 4'd0 && !(pri && bg[4:1] != 4'd0)) return {1'b1, spr};
    return bg[5:1];
  endfunction

  function automatic logic in_rect(input logic [9:0] x, input logic [9:0] y,
                                   input int x0, input int y0, input int w, input int h);
    return (int'(x) >= x0) && (int'(x) < x0 + w) && (int'(y) >= y0) && (int'(y) < y0 + h);
  endfunction

  // One pixel per clock: check the output of the pixel driven two cycles
  // ago, then drive the next pixel (plus any pending CPU write).
  task automatic step(input string tag, input logic [9:0] x, input logic [9:0] y,
                      input logic [5:0] bg, input logic pri, input logic [3:0] spr);
    logic [4:0] idx;
    @(negedge clk);
    if (exp_q.size() == 2) begin
      string t;
      t = tag_q.pop_front();
      check_eq({t, "/vp"},   {de_a, blue_a, green_a, red_a}, exp_q.pop_front());
      check_eq({t, "/full"}, {de_b, blue_b, green_b, red_b}, exp_b_q.pop_front());
    end else begin
      check_eq("fill/vp",   {de_a, blue_a, green_a, red_a}, 13'h0);
      check_eq("fill/full", {de_b, blue_b, green_b, red_b}, 13'h0);
    end
    rst = 1'b0;
    pixel_x = x; pixel_y = y; bg_color = bg; bg_priority = pri; spr_color = spr;
    backdrop = s_bd; mask_col0 = s_mask; display_en = s_den;
    cram_we = w_en; cram_a = w_a; cram_d = w_d;
    idx = model_index(x, y, bg, pri, spr);
    exp_q.push_back(in_rect(x, y, 48, 24, 160, 144) ? {1'b1, m_cram[idx]} : 13'h0);
    exp_b_q.push_back(in_rect(x, y, 0, 0, 256, 192) ? {1'b1, m_cram[idx]} : 13'h0);
    tag_q.push_back(tag);
    if (w_en) begin
      if (!w_a[0]) m_latch = w_d;
      else m_cram[w_a[5:1]] = {w_d[3:0], m_latch};
    end
    w_en = 1'b0;
  endtask

  task automatic idle();
    step("idle", 10'd300, 10'd250, 6'h00, 1'b0, 4'd0);
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    w_en = 1'b1; w_a = a; w_d = d;
    idle();
  endtask

  initial begin
    rst = 1'b1;
    pixel_x = '0; pixel_y = '0; bg_color = '0; bg_priority = 1'b0; spr_color = '0;
    backdrop = '0; mask_col0 = 1'b0; display_en = 1'b1;
    cram_we = 1'b0; cram_a = '0; cram_d = '0;
    s_bd = 4'd0; s_mask = 1'b0; s_den = 1'b1;
    w_en = 1'b0; w_a = '0; w_d = '0;
    m_latch = 8'h00;

    repeat (3) begin
      @(negedge clk);
      check_eq("rst_init/vp",   {de_a, blue_a, green_a, red_a}, 13'h0);
      check_eq("rst_init/full", {de_b, blue_b, green_b, red_b}, 13'h0);
    end

    for (int i = 0; i < 32; i++) begin
      wr(6'(2 * i), 8'($urandom_range(0, 255)));
      wr(6'(2 * i + 1), 8'($urandom_range(0, 255)));
    end

    wr(6'h02, 8'h2F);
    wr(6'h03, 8'h0A);
    step("pal", 10'd100, 10'd50, 6'h02, 1'b0, 4'd0);

    step("pri_bg",    10'd100, 10'd60, 6'h06, 1'b1, 4'd5);
    step("pri_spr",   10'd100, 10'd60, 6'h06, 1'b0, 4'd5);
    step("pri_clear", 10'd100, 10'd60, 6'h00, 1'b1, 4'd5);
    step("bg_upper",  10'd100, 10'd60, 6'h26, 1'b0, 4'd0);
    step("bg_zero",   10'd100, 10'd60, 6'h00, 1'b0, 4'd0);

    s_mask = 1'b1; s_bd = 4'd4;
    step("mask_x7", 10'd7, 10'd60, 6'h06, 1'b0, 4'd5);
    step("mask_x8", 10'd8, 10'd60, 6'h06, 1'b0, 4'd0);
    s_mask = 1'b0; s_den = 1'b0;
    step("den0_vp",  10'd100, 10'd60, 6'h06, 1'b1, 4'd5);
    step("den0_x0",  10'd0,   10'd0,  6'h06, 1'b0, 4'd0);
    s_den = 1'b1;

    step("vx47",  10'd47,  10'd24,  6'h06, 1'b0, 4'd0);
    step("vx48",  10'd48,  10'd24,  6'h06, 1'b0, 4'd0);
    step("vx207", 10'd207, 10'd24,  6'h06, 1'b0, 4'd0);
    step("vx208", 10'd208, 10'd24,  6'h06, 1'b0, 4'd0);
    step("vy23",  10'd100, 10'd23,  6'h06, 1'b0, 4'd0);
    step("vy167", 10'd100, 10'd167, 6'h06, 1'b0, 4'd0);
    step("vy168", 10'd100, 10'd168, 6'h06, 1'b0, 4'd0);

    wr(6'h02, 8'h34);
    w_en = 1'b1; w_a = 6'h03; w_d = 8'h05;
    step("coll_old", 10'd100, 10'd50, 6'h02, 1'b0, 4'd0);
    step("coll_new", 10'd100, 10'd50, 6'h02, 1'b0, 4'd0);

    for (int i = 0; i < 300; i++) begin
      s_bd   = 4'($urandom_range(0, 15));
      s_mask = ($urandom_range(0, 3) == 0);
      s_den  = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 7) == 0) begin
        w_en = 1'b1;
        w_a  = 6'($urandom_range(0, 63));
        w_d  = 8'($urandom_range(0, 255));
      end
      step("rand", 10'($urandom_range(0, 299)), 10'($urandom_range(0, 219)),
           6'($urandom_range(0, 31) * 2 + $urandom_range(0, 1) * 32),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end
    s_mask = 1'b0; s_den = 1'b1; s_bd = 4'd0;

    repeat (3) step("pre_rst", 10'd100, 10'd100, 6'h0A, 1'b0, 4'd0);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_async/vp",   {de_a, blue_a, green_a, red_a}, 13'h0);
    check_eq("rst_async/full", {de_b, blue_b, green_b, red_b}, 13'h0);
    exp_q.delete(); exp_b_q.delete(); tag_q.delete();
    m_latch = 8'h00;
    repeat (2) begin
      @(negedge clk);
      check_eq("rst_hold/vp",   {de_a, blue_a, green_a, red_a}, 13'h0);
      check_eq("rst_hold/full", {de_b, blue_b, green_b, red_b}, 13'h0);
    end
    step("post_rst0", 10'd100, 10'd100, 6'h0A, 1'b0, 4'd0);
    step("post_rst1", 10'd100, 10'd100, 6'h0A, 1'b0, 4'd0);
    wr(6'h0B, 8'h0B);
    step("latch_zero", 10'd100, 10'd100, 6'h0A, 1'b0, 4'd0);

    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
